// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: loads two WIDTH-bit operands and a carry-in,
// then drives a single generate/propagate full-adder cell one bit pair per
// clock, LSB first. The cell's carry is registered back as the next carry-in
// and the sum bits are collected MSB-first into an accumulator, so the result
// lines up once WIDTH bits have passed. sum/cout only change on completion.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit keeps the counter legal when WIDTH = 1.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_c;

    // Full-adder cell, generate/propagate form.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | ((x ^ y) & ci);
    endfunction

    assign fa_s     = fa_sum(opa_q[0], opb_q[0], carry_q);
    assign fa_c     = fa_carry(opa_q[0], opb_q[0], carry_q);
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Accumulator shifts right with this edge's sum bit entering at the MSB.
    always_comb begin
        acc_d            = acc_q >> 1;
        acc_d[WIDTH-1]   = fa_s;
    end

    // Next-state logic: start is honoured in IDLE and in the single DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/carry/accumulator datapath and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
            if (accept) begin
                opa_q   <= a;
                opb_q   <= b;
                carry_q <= cin;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                opa_q   <= opa_q >> 1;
                opb_q   <= opb_q >> 1;
                acc_q   <= acc_d;
                carry_q <= fa_c;
                cnt_q   <= cnt_q + CW'(1);
                if (last_bit) begin
                    sum  <= acc_d;
                    cout <= fa_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit and a 1-bit instance,
// table-driven vectors, hand-written multi-cycle sequences and random adds
// checked against plain-arithmetic expectations.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_checks;
    int n_fail;

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit addition: accept, scramble inputs, wait for done (bounded),
    // verify latency, in-flight stability of sum/cout/busy, and the result.
    // poke_at > 0 pulses start with junk operands during that RUN cycle.
    task automatic do_add8(input logic [7:0] ta, input logic [7:0] tb_,
                           input logic tc, input logic [7:0] es, input logic ec,
                           input int poke_at, input string nm);
        logic [7:0] prev_sum;
        logic       prev_cout;
        int         lat;
        bit         stable;
        prev_sum  = sum;
        prev_cout = cout;
        stable    = 1'b1;
        lat       = 0;
        start = 1'b1; a = ta; b = tb_; cin = tc;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        for (int i = 1; i <= 20; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || sum !== prev_sum || cout !== prev_cout)
                stable = 1'b0;
            if (i == poke_at) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({nm, " latency"}, 32'(lat), 32'd8);
        check({nm, " stable while running"}, 32'(stable), 32'd1);
        check({nm, " sum"}, 32'(sum), 32'(es));
        check({nm, " cout"}, 32'(cout), 32'(ec));
        tick();
        check({nm, " done one cycle"}, 32'({done, busy}), 32'd0);
    endtask

    task automatic do_add1(input logic ta, input logic tb_, input logic tc);
        logic [1:0] exp;
        int         lat;
        exp = 2'(ta) + 2'(tb_) + 2'(tc);
        lat = 0;
        start1 = 1'b1; a1 = ta; b1 = tb_; cin1 = tc;
        tick();
        start1 = 1'b0; a1 = ~ta; b1 = ~tb_; cin1 = ~tc;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (done1 === 1'b1) begin
                lat = i;
                break;
            end
        end
        check($sformatf("w1 %0d+%0d+%0d latency", ta, tb_, tc), 32'(lat), 32'd1);
        check($sformatf("w1 %0d+%0d+%0d result", ta, tb_, tc), 32'({cout1, sum1}), 32'(exp));
        tick();
    endtask

    vec_t vecs[8];

    initial begin
        int         ndone;
        int         lat;
        bit         nobusy;
        logic [8:0] expv;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

        rst = 1'b1;
        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        #12;
        check("reset outputs", 32'({busy, done, cout, sum}), 32'd0);
        check("reset outputs w1", 32'({busy1, done1, cout1, sum1}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle after reset", 32'({busy, done, cout, sum}), 32'd0);

        // Table-driven vectors.
        foreach (vecs[i])
            do_add8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum,
                    vecs[i].exp_cout, 0, $sformatf("vec%0d", i));

        // start mid-RUN is ignored.
        do_add8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3, "midrun start");

        // Back-to-back with start held high.
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        tick();
        a = 8'h80; b = 8'h80;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done === 1'b1) begin lat = i; break; end
        end
        check("b2b first latency", 32'(lat), 32'd8);
        check("b2b first result", 32'({cout, sum}), 32'h002);
        tick();
        start = 1'b0;
        check("b2b no gap busy", 32'({busy, done}), 32'h2);
        lat = 1;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (done === 1'b1) begin lat = i; break; end
        end
        check("b2b done spacing", 32'(lat), 32'd9);
        check("b2b second result", 32'({cout, sum}), 32'h100);
        tick();

        // Asynchronous reset in the middle of a run.
        do_add8(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 0, "pre-reset");
        start = 1'b1; a = 8'h0F; b = 8'h0F; cin = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async reset outputs", 32'({busy, done, cout, sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone  = 0;
        nobusy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) ndone++;
            if (busy !== 1'b0) nobusy = 1'b0;
        end
        check("no done after reset abort", 32'(ndone), 32'd0);
        check("stays idle after reset", 32'(nobusy), 32'd1);
        do_add8(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 0, "fresh after reset");

        // Randomised adds against plain arithmetic.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            expv = 9'(ra) + 9'(rb) + 9'(rc);
            do_add8(ra, rb, rc, expv[7:0], expv[8], 0, $sformatf("rand%0d", i));
        end

        // WIDTH = 1: exhaustive.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            do_add1(v[2], v[1], v[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
